// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - four-digit BCD display scanner with frame-aligned load and leading-zero blanking
module display_scan_mux #(
    parameter int CLK_DIV  = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [3:0]  digit_code,
    output logic [3:0]  digit_sel,
    output logic        frame_done
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   pending;

    logic          tick;
    logic          boundary;
    logic          accept;
    logic [1:0]    idx_n;
    logic [15:0]   shadow_n;
    logic [3:0]    code_n;
    logic          blank;

    assign tick     = (presc == CW'(CLK_DIV - 1));
    assign boundary = tick && (idx == 2'd3);
    assign accept   = load_valid && load_ready;

    // Outputs are registered from next-state values so they track the new slot immediately.
    always_comb begin
        idx_n    = tick ? idx + 2'd1 : idx;
        shadow_n = (boundary && !load_ready) ? pending : shadow;
        blank    = 1'b0;
        case (idx_n)
            2'd1:    blank = (shadow_n[15:4]  == 12'h000);
            2'd2:    blank = (shadow_n[15:8]  == 8'h00);
            2'd3:    blank = (shadow_n[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        code_n = shadow_n[{idx_n, 2'b00} +: 4];
        if ((BLANK_LZ != 0) && blank) begin
            code_n = 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= 2'd0;
            shadow     <= 16'h0000;
            pending    <= 16'h0000;
            load_ready <= 1'b1;
            digit_sel  <= 4'b1110;
            digit_code <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + CW'(1);
            idx        <= idx_n;
            shadow     <= shadow_n;
            if (accept) begin
                pending <= bcd_in;
            end
            // load_ready is the inverted pending-full flag; capture cannot coincide with a transfer.
            if (boundary && !load_ready) begin
                load_ready <= 1'b1;
            end else if (accept) begin
                load_ready <= 1'b0;
            end
            digit_sel  <= ~(4'b0001 << idx_n);
            digit_code <= code_n;
            frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - scoreboard bench for display_scan_mux against a cycle-count reference model
module tb_display_scan_mux;
    localparam int CDIV  = 4;
    localparam int FRAME = 4 * CDIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        load_valid;

    logic        ready1, ready0, fd1, fd0;
    logic [3:0]  code1, code0, sel1, sel0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    display_scan_mux #(.CLK_DIV(CDIV), .BLANK_LZ(1)) dut1 (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load_valid(load_valid),
        .load_ready(ready1), .digit_code(code1), .digit_sel(sel1), .frame_done(fd1)
    );

    display_scan_mux #(.CLK_DIV(CDIV), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load_valid(load_valid),
        .load_ready(ready0), .digit_code(code0), .digit_sel(sel0), .frame_done(fd0)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] c1;
        logic [3:0] c0;
        logic       rdy;
        logic       fd;
    } exp_t;

    exp_t        sbq[$];
    int          n_cnt = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_pend[$];

    function automatic logic [3:0] exp_code(input logic [15:0] sh, input int k, input bit blank_en);
        logic [15:0] upper;
        upper = sh >> (4 * k);
        if (blank_en && k > 0 && upper == 16'h0000) return 4'hF;
        return upper[3:0];
    endfunction

    // Reference: elapsed edges since reset determine slot and frame; pending is a one-deep queue.
    always @(posedge clk) begin
        exp_t        e;
        logic        bnd;
        int          k;
        logic [3:0]  one;
        one = 4'b0001;
        bnd = 1'b0;
        if (rst) begin
            n_cnt    = 0;
            m_shadow = 16'h0000;
            m_pend.delete();
        end else begin
            n_cnt++;
            bnd = (n_cnt % FRAME == 0);
            if (bnd && m_pend.size() > 0) m_shadow = m_pend.pop_front();
            else if (load_valid && m_pend.size() == 0) m_pend.push_back(bcd_in);
        end
        k     = (n_cnt / CDIV) % 4;
        e.sel = ~(one << k);
        e.c1  = exp_code(m_shadow, k, 1'b1);
        e.c0  = exp_code(m_shadow, k, 1'b0);
        e.rdy = (m_pend.size() == 0);
        e.fd  = bnd;
        sbq.push_back(e);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("digit_sel",   {12'h0, sel1},   {12'h0, e.sel});
            chk("digit_code",  {12'h0, code1},  {12'h0, e.c1});
            chk("load_ready",  {15'h0, ready1}, {15'h0, e.rdy});
            chk("frame_done",  {15'h0, fd1},    {15'h0, e.fd});
            chk("sel_nolz",    {12'h0, sel0},   {12'h0, e.sel});
            chk("code_nolz",   {12'h0, code0},  {12'h0, e.c0});
            chk("ready_nolz",  {15'h0, ready0}, {15'h0, e.rdy});
            chk("frame_nolz",  {15'h0, fd0},    {15'h0, e.fd});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v);
        bcd_in     = v;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Wait until the next rising edge will be edge number p (mod FRAME) after reset.
    task automatic wait_phase(input int p);
        int b;
        b = 0;
        while (((n_cnt + 1) % FRAME) != p && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (b >= 100) begin
            total++;
            bad++;
            $display("FAIL wait_phase: phase %0d not reached, got %0d", p, (n_cnt + 1) % FRAME);
        end
    endtask

    initial begin
        logic [15:0] v;
        rst        = 1'b1;
        load_valid = 1'b0;
        bcd_in     = 16'h0000;
        idle(3);
        rst = 1'b0;
        idle(40);

        wait_phase(6);
        load(16'h1234);
        idle(40);

        load(16'h0070);
        idle(40);

        bcd_in     = 16'h1111;
        load_valid = 1'b1;
        @(negedge clk);
        bcd_in = 16'h2222;
        @(negedge clk);
        load_valid = 1'b0;
        idle(40);

        wait_phase(0);
        load(16'h5678);
        idle(40);

        wait_phase(5);
        load(16'h9A0B);
        wait_phase(9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(40);

        for (int i = 0; i < 800; i++) begin
            for (int d = 0; d < 4; d++) begin
                v[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            bcd_in     = v;
            load_valid = ($urandom_range(0, 5) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst        = 1'b0;
        load_valid = 1'b0;
        idle(40);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(sbq.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, giving the clock cycles per digit slot; legal values are 2 or more.
REQ-002 The block SHALL have parameter BLANK_LZ, default 1, where 1 enables leading-zero blanking.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port bcd_in  input  16  four BCD digits, [15:12]=digit3 (MSD) ... [3:0]=digit0 (LSD).
REQ-006 The block SHALL have port load_valid  input  1  bcd_in holds a new value to display.
REQ-007 The block SHALL have port load_ready  output  1  the block can accept bcd_in this cycle.
REQ-008 The block SHALL have port digit_code  output  4  code for the active digit, fed to the 7-segment decoder's 4-bit input.
REQ-009 The block SHALL have port digit_sel  output  4  active-low anode enables, one bit per digit.
REQ-010 The block SHALL have port frame_done  output  1  one-cycle pulse when a 4-digit scan frame completes.

Function
REQ-011 Prescaler: the block SHALL count 0..CLK_DIV-1 and wrap to 0; the cycle where it reads CLK_DIV-1 is a "slot tick".
REQ-012 Scan index: the block SHALL hold a 2-bit index that advances 0->1->2->3->0 on each slot tick and never otherwise changes (except reset).
REQ-013 All outputs SHALL be registered; digit_sel and digit_code SHALL reflect the new index in the cycle after the slot tick.
REQ-014 digit_sel SHALL equal ~(4'b0001 << index): exactly one bit low at all times, including reset.
REQ-015 digit_code SHALL equal the shadow-register digit selected by index, unless that digit is blanked.
REQ-016 Blanking: with BLANK_LZ=1, digit k (k=3,2,1) SHALL be blanked when it and every higher shadow digit equal 0; digit0 is never blanked.
REQ-017 Blanking: with BLANK_LZ=0, no digit SHALL be blanked.
REQ-018 A blanked digit SHALL drive digit_code=4'hF, which the decoder renders all segments off.
REQ-019 Shadow digits 10-15 SHALL pass through unmodified; the decoder renders them all segments off.
REQ-020 Handshake: bcd_in SHALL be captured into a pending register on a cycle where load_valid && load_ready.
REQ-021 load_ready SHALL be 0 while the pending register is full and 1 while it is empty.
REQ-022 Frame boundary: this is the slot tick with index=3. If pending is full, the block SHALL copy pending to shadow and empty pending on that cycle.
REQ-023 The new shadow value SHALL first appear on digit_code for digit0 in the following cycle, and load_ready SHALL return to 1 in that same cycle.
REQ-024 A capture occurring on the same cycle as a frame boundary SHALL NOT transfer until the next boundary; the shadow is never updated mid-frame.
REQ-025 Latency from an accepted load to display SHALL be between 1 and 4*CLK_DIV cycles.
REQ-026 load_valid while load_ready=0 SHALL be ignored; the pending contents SHALL NOT be overwritten.
REQ-027 frame_done SHALL be 1 exactly in the cycle after each frame boundary, whether or not a transfer occurred, and 0 otherwise.

Reset
REQ-028 On a clock edge with rst=1, the block SHALL set: prescaler=0, index=0, shadow=16'h0000, pending empty.
REQ-029 On a clock edge with rst=1, the block SHALL set outputs: load_ready=1, digit_sel=4'b1110, digit_code=4'h0, frame_done=0.
REQ-030 rst SHALL override all other activity, including mid-frame and with a load pending; the pending value SHALL be discarded.
REQ-031 The first slot tick after rst deasserts SHALL occur CLK_DIV cycles later.

Verification (bench uses CLK_DIV=4, BLANK_LZ=1 unless stated)
REQ-032 Scan sequence: after reset with no loads, digit_sel SHALL cycle 1110,1101,1011,0111, each for 4 cycles, and digit_code SHALL be 0,F,F,F; frame_done SHALL pulse every 16 cycles.
REQ-033 Load 16'h1234 mid-frame: load_ready SHALL fall for that frame; after the boundary, digit_code SHALL read 4,3,2,1 per slot.
REQ-034 Load 16'h0070: digits SHALL show 0,7,F,F; the same load with BLANK_LZ=0 SHALL show 0,7,0,0.
REQ-035 Back-to-back load_valid with 16'h1111 then 16'h2222 while ready=0: 16'h1111 SHALL be displayed, 16'h2222 ignored, and ready SHALL reassert after the boundary.
REQ-036 Load accepted on the boundary cycle itself: the shadow SHALL stay old for the full next frame and update one boundary later.
REQ-037 Assert rst during slot 2 with a load pending: the block SHALL reach the REQ-028/029 values the next cycle, with the pending value lost.
